// File: rtl/rmap_pkg.sv
// Shared RMAP status codes, instruction-field constants and state types used by
// the target authentication/status block and its header checker.
package rmap_pkg;

  localparam logic [7:0] RMAP_OK        = 8'd0;
  localparam logic [7:0] ERR_CMD        = 8'd2;
  localparam logic [7:0] ERR_KEY        = 8'd3;
  localparam logic [7:0] ERR_DCRC       = 8'd4;
  localparam logic [7:0] ERR_EARLY_EOP  = 8'd5;
  localparam logic [7:0] ERR_TOO_MUCH   = 8'd6;
  localparam logic [7:0] ERR_EEP        = 8'd7;
  localparam logic [7:0] ERR_VERIFY_OVR = 8'd9;
  localparam logic [7:0] ERR_NOT_AUTH   = 8'd10;
  localparam logic [7:0] ERR_RMW_LEN    = 8'd11;
  localparam logic [7:0] ERR_TLA        = 8'd12;

  localparam logic [1:0]  PKT_COMMAND    = 2'b01;
  localparam logic [3:0]  CMD_READ_SGL   = 4'b0010;
  localparam logic [3:0]  CMD_READ_INC   = 4'b0011;
  localparam logic [3:0]  CMD_RMW        = 4'b0111;
  localparam logic [23:0] RMW_MAX_LEN    = 24'd8;
  localparam logic [23:0] VERIFY_MAX_LEN = 24'd4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_DATA  = 2'd1,
    ST_WAIT_REPLY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_RMW   = 2'd3
  } op_t;

  typedef struct packed {
    logic       pass;
    logic [7:0] code;
    logic       addr_bad;
    logic       len_bad;
    op_t        op;
  } verdict_t;

  function automatic op_t decode_op(input logic [3:0] cmd);
    if (cmd[3]) return OP_WRITE;
    if (cmd == CMD_READ_SGL || cmd == CMD_READ_INC) return OP_READ;
    if (cmd == CMD_RMW) return OP_RMW;
    return OP_NONE;
  endfunction

  // Data-phase error priority: EEP, early EOP, too much data, then data CRC.
  function automatic logic [7:0] data_phase_code(input logic eep, input logic early_eop,
                                                 input logic too_much, input logic crc_err);
    if (eep)       return ERR_EEP;
    if (early_eop) return ERR_EARLY_EOP;
    if (too_much)  return ERR_TOO_MUCH;
    if (crc_err)   return ERR_DCRC;
    return RMAP_OK;
  endfunction

endpackage

// File: rtl/rmap_hdr_check.sv
// Combinational RMAP header checker: TLA, command, key, address range and length
// limits evaluated in priority order into a single verdict (zero latency, no backpressure).
module rmap_hdr_check
  import rmap_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'h0000_FFFF,
  parameter logic [23:0] MAX_LEN = 24'd256
) (
  input  logic [7:0]  tla_i,
  input  logic [7:0]  instr_i,
  input  logic [7:0]  key_i,
  input  logic [31:0] addr_i,
  input  logic [23:0] len_i,
  input  logic [7:0]  cfg_tla_i,
  input  logic [7:0]  cfg_key_i,
  output verdict_t    verdict_o
);

  logic [3:0]  cmd;
  op_t         op;
  logic        pkt_ok;
  logic        verify;
  logic [32:0] addr_ext;
  logic [32:0] last_addr;
  logic [32:0] lo_diff;
  logic        range_bad;
  logic        rmw_len_bad;
  logic        verify_len_bad;
  logic        max_len_bad;
  logic        instr_unused;

  assign cmd          = instr_i[5:2];
  assign op           = decode_op(cmd);
  assign pkt_ok       = (instr_i[7:6] == PKT_COMMAND);
  assign verify       = cmd[3] & cmd[2];
  assign instr_unused = ^instr_i[1:0];

  // 33-bit so address + length cannot wrap; a zero length only checks the start.
  assign addr_ext  = {1'b0, addr_i};
  assign last_addr = (len_i == '0) ? addr_ext : (addr_ext + {9'd0, len_i} - 33'd1);
  assign lo_diff   = addr_ext - {1'b0, ADDR_LO};
  assign range_bad = lo_diff[32] | (last_addr > {1'b0, ADDR_HI});

  assign rmw_len_bad    = (len_i > RMW_MAX_LEN) | len_i[0];
  assign verify_len_bad = verify & (len_i > VERIFY_MAX_LEN);
  assign max_len_bad    = ((op == OP_WRITE) || (op == OP_READ)) && (len_i > MAX_LEN);

  always_comb begin
    verdict_o    = '0;
    verdict_o.op = op;
    if (tla_i != cfg_tla_i) begin
      verdict_o.code = ERR_TLA;
    end else if (!pkt_ok || op == OP_NONE) begin
      verdict_o.code = ERR_CMD;
    end else if (key_i != cfg_key_i) begin
      verdict_o.code = ERR_KEY;
    end else if (range_bad) begin
      verdict_o.code     = ERR_NOT_AUTH;
      verdict_o.addr_bad = 1'b1;
    end else if (op == OP_RMW && rmw_len_bad) begin
      verdict_o.code    = ERR_RMW_LEN;
      verdict_o.len_bad = 1'b1;
    end else if (op == OP_WRITE && verify_len_bad) begin
      verdict_o.code    = ERR_VERIFY_OVR;
      verdict_o.len_bad = 1'b1;
    end else if (max_len_bad) begin
      verdict_o.code    = ERR_NOT_AUTH;
      verdict_o.len_bad = 1'b1;
    end else begin
      verdict_o.pass = 1'b1;
      verdict_o.code = RMAP_OK;
    end
  end

endmodule

// File: rtl/rmap_status_modport.sv
// RMAP target authentication/status FSM: header verdict and completion status are
// registered one cycle after the input pulse; no backpressure, out-of-state pulses are dropped.
module rmap_status_modport
  import rmap_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'h0000_FFFF,
  parameter logic [23:0] MAX_LEN = 24'd256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  configKey,
  input  logic [7:0]  logicalAddress,
  input  logic        hdrValid,
  input  logic [7:0]  hdrTla,
  input  logic [7:0]  hdrInstr,
  input  logic [7:0]  hdrKey,
  input  logic [31:0] hdrAddr,
  input  logic [23:0] hdrLen,
  input  logic        dataDone,
  input  logic        dataCrcErr,
  input  logic        earlyEop,
  input  logic        eep,
  input  logic        tooMuchData,
  input  logic        replyDone,
  output logic        authOk,
  output logic [7:0]  rmapErrorCode,
  output logic        errorIndication,
  output logic        writeDataIndication,
  output logic        readDataIndication,
  output logic        rmwDataIndication,
  output logic        addrInvalid,
  output logic        dataLengthInvalid
);

  verdict_t   verdict;
  logic [7:0] data_code;

  state_t     state_q;
  op_t        op_q;
  logic       auth_q;
  logic       err_q;
  logic       wr_ind_q;
  logic       rd_ind_q;
  logic       rmw_ind_q;
  logic [7:0] code_q;
  logic       addr_inv_q;
  logic       len_inv_q;

  rmap_hdr_check #(
    .ADDR_LO (ADDR_LO),
    .ADDR_HI (ADDR_HI),
    .MAX_LEN (MAX_LEN)
  ) u_hdr_check (
    .tla_i     (hdrTla),
    .instr_i   (hdrInstr),
    .key_i     (hdrKey),
    .addr_i    (hdrAddr),
    .len_i     (hdrLen),
    .cfg_tla_i (logicalAddress),
    .cfg_key_i (configKey),
    .verdict_o (verdict)
  );

  assign data_code = data_phase_code(eep, earlyEop, tooMuchData, dataCrcErr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NONE;
      auth_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ind_q   <= 1'b0;
      rd_ind_q   <= 1'b0;
      rmw_ind_q  <= 1'b0;
      code_q     <= RMAP_OK;
      addr_inv_q <= 1'b0;
      len_inv_q  <= 1'b0;
    end else begin
      // Every indication is a single-cycle pulse unless re-asserted below.
      auth_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_ind_q  <= 1'b0;
      rd_ind_q  <= 1'b0;
      rmw_ind_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hdrValid) begin
            code_q     <= verdict.code;
            addr_inv_q <= verdict.addr_bad;
            len_inv_q  <= verdict.len_bad;
            if (verdict.pass) begin
              auth_q  <= 1'b1;
              op_q    <= verdict.op;
              state_q <= (verdict.op == OP_READ) ? ST_WAIT_REPLY : ST_WAIT_DATA;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_WAIT_DATA: begin
          if (dataDone) begin
            code_q  <= data_code;
            state_q <= ST_IDLE;
            if (data_code != RMAP_OK) begin
              err_q <= 1'b1;
            end else if (op_q == OP_RMW) begin
              rmw_ind_q <= 1'b1;
            end else begin
              wr_ind_q <= 1'b1;
            end
          end
        end
        ST_WAIT_REPLY: begin
          if (replyDone) begin
            code_q   <= RMAP_OK;
            rd_ind_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign authOk              = auth_q;
  assign errorIndication     = err_q;
  assign writeDataIndication = wr_ind_q;
  assign readDataIndication  = rd_ind_q;
  assign rmwDataIndication   = rmw_ind_q;
  assign rmapErrorCode       = code_q;
  assign addrInvalid         = addr_inv_q;
  assign dataLengthInvalid   = len_inv_q;

endmodule

// File: tb/tb_rmap_status_modport.sv
// Bench for rmap_status_modport: directed scenarios plus randomized headers and
// completions compared against a rule-level model of the target's verdicts.
module tb_rmap_status_modport;

  localparam longint M_ADDR_LO = 64'h0;
  localparam longint M_ADDR_HI = 64'hFFFF;
  localparam longint M_MAX_LEN = 256;

  logic        clk;
  logic        rst_n;
  logic [7:0]  configKey;
  logic [7:0]  logicalAddress;
  logic        hdrValid;
  logic [7:0]  hdrTla;
  logic [7:0]  hdrInstr;
  logic [7:0]  hdrKey;
  logic [31:0] hdrAddr;
  logic [23:0] hdrLen;
  logic        dataDone;
  logic        dataCrcErr;
  logic        earlyEop;
  logic        eep;
  logic        tooMuchData;
  logic        replyDone;
  logic        authOk;
  logic [7:0]  rmapErrorCode;
  logic        errorIndication;
  logic        writeDataIndication;
  logic        readDataIndication;
  logic        rmwDataIndication;
  logic        addrInvalid;
  logic        dataLengthInvalid;

  int n_tot;
  int n_pass;

  // Model: 0 idle, 1 write pending, 2 RMW pending, 3 read pending.
  int          m_pend;
  logic [7:0]  m_code;
  logic        m_ai;
  logic        m_dli;
  logic [14:0] exp_vec;

  rmap_status_modport dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .configKey           (configKey),
    .logicalAddress      (logicalAddress),
    .hdrValid            (hdrValid),
    .hdrTla              (hdrTla),
    .hdrInstr            (hdrInstr),
    .hdrKey              (hdrKey),
    .hdrAddr             (hdrAddr),
    .hdrLen              (hdrLen),
    .dataDone            (dataDone),
    .dataCrcErr          (dataCrcErr),
    .earlyEop            (earlyEop),
    .eep                 (eep),
    .tooMuchData         (tooMuchData),
    .replyDone           (replyDone),
    .authOk              (authOk),
    .rmapErrorCode       (rmapErrorCode),
    .errorIndication     (errorIndication),
    .writeDataIndication (writeDataIndication),
    .readDataIndication  (readDataIndication),
    .rmwDataIndication   (rmwDataIndication),
    .addrInvalid         (addrInvalid),
    .dataLengthInvalid   (dataLengthInvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {authOk, errorIndication, write, read, rmw, addrInvalid, dataLengthInvalid, code}
  function automatic logic [14:0] obs();
    return {authOk, errorIndication, writeDataIndication, readDataIndication,
            rmwDataIndication, addrInvalid, dataLengthInvalid, rmapErrorCode};
  endfunction

  function automatic void model_hdr(input logic [7:0] tla, input logic [7:0] instr,
                                    input logic [7:0] key, input logic [31:0] addr,
                                    input logic [23:0] len, output bit pass,
                                    output int code, output bit ai, output bit dli);
    int     c;
    bit     is_wr, is_rd, is_rmw;
    longint first, last;
    c      = int'(instr[5:2]);
    is_wr  = (c >= 8);
    is_rd  = (c == 2) || (c == 3);
    is_rmw = (c == 7);
    first  = longint'({32'd0, addr});
    last   = (len == 0) ? first : first + longint'({40'd0, len}) - 1;
    pass = 0; ai = 0; dli = 0; code = 0;
    if (tla != logicalAddress) code = 12;
    else if (instr[7:6] != 2'b01 || !(is_wr || is_rd || is_rmw)) code = 2;
    else if (key != configKey) code = 3;
    else if (first < M_ADDR_LO || last > M_ADDR_HI) begin code = 10; ai = 1; end
    else if (is_rmw && !(len inside {24'd0, 24'd2, 24'd4, 24'd6, 24'd8})) begin code = 11; dli = 1; end
    else if (is_wr && c >= 12 && len > 4) begin code = 9; dli = 1; end
    else if ((is_wr || is_rd) && longint'({40'd0, len}) > M_MAX_LEN) begin code = 10; dli = 1; end
    else pass = 1;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_code = 8'd0; m_ai = 1'b0; m_dli = 1'b0;
  endtask

  // Drivers start at a falling edge and return at the next falling edge.
  task automatic apply_hdr(input logic [7:0] tla, input logic [7:0] instr, input logic [7:0] key,
                           input logic [31:0] addr, input logic [23:0] len);
    bit pass, ai, dli;
    int code, c;
    hdrTla = tla; hdrInstr = instr; hdrKey = key; hdrAddr = addr; hdrLen = len;
    hdrValid = 1'b1;
    if (m_pend == 0) begin
      model_hdr(tla, instr, key, addr, len, pass, code, ai, dli);
      m_code = 8'(code); m_ai = ai; m_dli = dli;
      if (pass) begin
        c = int'(instr[5:2]);
        m_pend = (c >= 8) ? 1 : (c == 7) ? 2 : 3;
      end
      exp_vec = {pass, !pass, 3'b000, ai, dli, 8'(code)};
    end else begin
      exp_vec = {5'b0, m_ai, m_dli, m_code};
    end
    @(negedge clk);
    hdrValid = 1'b0;
  endtask

  task automatic apply_done(input bit e, input bit early, input bit tmd, input bit crc);
    int code;
    dataDone = 1'b1; eep = e; earlyEop = early; tooMuchData = tmd; dataCrcErr = crc;
    if (m_pend == 1 || m_pend == 2) begin
      code = e ? 7 : early ? 5 : tmd ? 6 : crc ? 4 : 0;
      m_code = 8'(code);
      exp_vec = {1'b0, code != 0, code == 0 && m_pend == 1, 1'b0, code == 0 && m_pend == 2,
                 m_ai, m_dli, m_code};
      m_pend = 0;
    end else begin
      exp_vec = {5'b0, m_ai, m_dli, m_code};
    end
    @(negedge clk);
    dataDone = 1'b0; eep = 1'b0; earlyEop = 1'b0; tooMuchData = 1'b0; dataCrcErr = 1'b0;
  endtask

  task automatic apply_reply();
    replyDone = 1'b1;
    if (m_pend == 3) begin
      m_code = 8'd0;
      exp_vec = {5'b00010, m_ai, m_dli, 8'd0};
      m_pend = 0;
    end else begin
      exp_vec = {5'b0, m_ai, m_dli, m_code};
    end
    @(negedge clk);
    replyDone = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    exp_vec = {5'b0, m_ai, m_dli, m_code};
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tot++; if (obs() !== 15'd0) $display("FAIL reset_state got %h want %h", obs(), 15'd0); else n_pass++;
    rst_n = 1'b1;
    model_reset();
    idle_cycle();
    n_tot++; if (obs() !== exp_vec) $display("FAIL reset_release got %h want %h", obs(), exp_vec); else n_pass++;
  endtask

  task automatic test_write_ok();
    apply_hdr(8'hFE, 8'h6C, 8'h20, 32'h10, 24'd4);
    n_tot++; if (obs() !== exp_vec) $display("FAIL write_hdr got %h want %h", obs(), exp_vec); else n_pass++;
    n_tot++; if ({authOk, errorIndication} !== 2'b10) $display("FAIL write_auth got %b want 10", {authOk, errorIndication}); else n_pass++;
    idle_cycle();
    n_tot++; if (obs() !== exp_vec) $display("FAIL write_auth_width got %h want %h", obs(), exp_vec); else n_pass++;
    apply_done(0, 0, 0, 0);
    n_tot++; if (obs() !== exp_vec) $display("FAIL write_done got %h want %h", obs(), exp_vec); else n_pass++;
    n_tot++; if ({writeDataIndication, rmapErrorCode} !== 9'h100) $display("FAIL write_ind got %h want 100", {writeDataIndication, rmapErrorCode}); else n_pass++;
    idle_cycle();
    n_tot++; if (obs() !== exp_vec) $display("FAIL write_ind_width got %h want %h", obs(), exp_vec); else n_pass++;
  endtask

  task automatic test_key_bad();
    apply_hdr(8'hFE, 8'h6C, 8'h21, 32'h10, 24'd4);
    n_tot++; if (obs() !== exp_vec) $display("FAIL key_bad got %h want %h", obs(), exp_vec); else n_pass++;
    n_tot++; if ({authOk, errorIndication, rmapErrorCode} !== 10'h103) $display("FAIL key_code got %h want 103", {authOk, errorIndication, rmapErrorCode}); else n_pass++;
    idle_cycle();
    n_tot++; if (obs() !== exp_vec) $display("FAIL key_hold got %h want %h", obs(), exp_vec); else n_pass++;
  endtask

  task automatic test_priority();
    apply_hdr(8'hFD, 8'h6C, 8'h21, 32'h10, 24'd4);
    n_tot++; if (rmapErrorCode !== 8'd12) $display("FAIL prio_tla got %0d want 12", rmapErrorCode); else n_pass++;
    apply_hdr(8'hFE, 8'h58, 8'h21, 32'h10, 24'd4);
    n_tot++; if (obs() !== exp_vec) $display("FAIL prio_cmd got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'hAC, 8'h20, 32'h10, 24'd4);
    n_tot++; if (obs() !== exp_vec) $display("FAIL prio_pkt got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'h6C, 8'h21, 32'hFFFF, 24'd300);
    n_tot++; if (obs() !== exp_vec) $display("FAIL prio_key_over_addr got %h want %h", obs(), exp_vec); else n_pass++;
  endtask

  task automatic test_limits();
    apply_hdr(8'hFE, 8'h48, 8'h20, 32'hFFFF, 24'd2);
    n_tot++; if ({addrInvalid, dataLengthInvalid, rmapErrorCode} !== 10'h20A) $display("FAIL addr_over got %h want 20A", {addrInvalid, dataLengthInvalid, rmapErrorCode}); else n_pass++;
    apply_hdr(8'hFE, 8'h48, 8'h20, 32'h0, 24'd257);
    n_tot++; if ({addrInvalid, dataLengthInvalid, rmapErrorCode} !== 10'h10A) $display("FAIL len_over got %h want 10A", {addrInvalid, dataLengthInvalid, rmapErrorCode}); else n_pass++;
    apply_hdr(8'hFE, 8'h70, 8'h20, 32'h0, 24'd5);
    n_tot++; if (obs() !== exp_vec) $display("FAIL verify_len got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'h48, 8'h20, 32'h0001_0000, 24'd0);
    n_tot++; if (obs() !== exp_vec) $display("FAIL addr_len0 got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'h48, 8'h20, 32'hFFFF, 24'd1);
    n_tot++; if (obs() !== exp_vec) $display("FAIL addr_edge got %h want %h", obs(), exp_vec); else n_pass++;
    apply_reply();
    n_tot++; if (obs() !== exp_vec) $display("FAIL read_done got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'h4C, 8'h20, 32'h0, 24'd256);
    n_tot++; if (obs() !== exp_vec) $display("FAIL len_edge got %h want %h", obs(), exp_vec); else n_pass++;
    apply_reply();
    n_tot++; if (obs() !== exp_vec) $display("FAIL read_inc_done got %h want %h", obs(), exp_vec); else n_pass++;
  endtask

  task automatic test_rmw();
    apply_hdr(8'hFE, 8'h5C, 8'h20, 32'h100, 24'd3);
    n_tot++; if ({dataLengthInvalid, rmapErrorCode} !== 9'h10B) $display("FAIL rmw_len got %h want 10B", {dataLengthInvalid, rmapErrorCode}); else n_pass++;
    apply_hdr(8'hFE, 8'h5C, 8'h20, 32'h100, 24'd8);
    n_tot++; if (obs() !== exp_vec) $display("FAIL rmw_hdr got %h want %h", obs(), exp_vec); else n_pass++;
    apply_done(0, 0, 0, 0);
    n_tot++; if ({rmwDataIndication, writeDataIndication} !== 2'b10) $display("FAIL rmw_ind got %b want 10", {rmwDataIndication, writeDataIndication}); else n_pass++;
    n_tot++; if (obs() !== exp_vec) $display("FAIL rmw_done got %h want %h", obs(), exp_vec); else n_pass++;
  endtask

  task automatic test_data_errors();
    apply_hdr(8'hFE, 8'h6C, 8'h20, 32'h10, 24'd4);
    apply_done(0, 0, 0, 1);
    n_tot++; if ({errorIndication, rmapErrorCode} !== 9'h104) $display("FAIL data_crc got %h want 104", {errorIndication, rmapErrorCode}); else n_pass++;
    apply_hdr(8'hFE, 8'h6C, 8'h20, 32'h10, 24'd4);
    apply_done(1, 0, 0, 1);
    n_tot++; if (obs() !== exp_vec) $display("FAIL data_eep got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'h6C, 8'h20, 32'h10, 24'd4);
    apply_done(0, 1, 1, 0);
    n_tot++; if (obs() !== exp_vec) $display("FAIL data_early got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'h6C, 8'h20, 32'h10, 24'd4);
    apply_done(0, 0, 1, 1);
    n_tot++; if (obs() !== exp_vec) $display("FAIL data_toomuch got %h want %h", obs(), exp_vec); else n_pass++;
  endtask

  task automatic test_ignore();
    apply_reply();
    n_tot++; if (obs() !== exp_vec) $display("FAIL idle_reply got %h want %h", obs(), exp_vec); else n_pass++;
    apply_done(0, 0, 0, 0);
    n_tot++; if (obs() !== exp_vec) $display("FAIL idle_done got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'h48, 8'h20, 32'h20, 24'd4);
    apply_done(0, 0, 0, 0);
    n_tot++; if (obs() !== exp_vec) $display("FAIL reply_state_done got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'h6C, 8'h21, 32'h10, 24'd4);
    n_tot++; if ({errorIndication, rmapErrorCode} !== 9'h000) $display("FAIL busy_hdr got %h want 000", {errorIndication, rmapErrorCode}); else n_pass++;
    apply_reply();
    n_tot++; if (obs() !== exp_vec) $display("FAIL reply_after_ignore got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'h6C, 8'h20, 32'h10, 24'd4);
    apply_reply();
    n_tot++; if (obs() !== exp_vec) $display("FAIL data_state_reply got %h want %h", obs(), exp_vec); else n_pass++;
    apply_done(0, 0, 0, 0);
    n_tot++; if (obs() !== exp_vec) $display("FAIL data_state_done got %h want %h", obs(), exp_vec); else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_hdr(8'hFE, 8'h6C, 8'h20, 32'h10, 24'd4);
    hdrTla = 8'hFE; hdrInstr = 8'h6C; hdrKey = 8'h21; hdrAddr = 32'h10; hdrLen = 24'd4;
    hdrValid = 1'b1; dataDone = 1'b1;
    @(negedge clk);
    hdrValid = 1'b0; dataDone = 1'b0;
    m_pend = 0; m_code = 8'd0;
    n_tot++; if (obs() !== 15'h1000) $display("FAIL simul_done_hdr got %h want %h", obs(), 15'h1000); else n_pass++;
    apply_hdr(8'hFE, 8'h5C, 8'h20, 32'h40, 24'd2);
    n_tot++; if (obs() !== exp_vec) $display("FAIL b2b_hdr got %h want %h", obs(), exp_vec); else n_pass++;
    apply_done(0, 0, 0, 0);
    n_tot++; if (obs() !== exp_vec) $display("FAIL b2b_done got %h want %h", obs(), exp_vec); else n_pass++;
    apply_hdr(8'hFE, 8'h48, 8'h20, 32'hFFF0, 24'd17);
    n_tot++; if (obs() !== exp_vec) $display("FAIL b2b_bad got %h want %h", obs(), exp_vec); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_hdr(8'hFE, 8'h6C, 8'h21, 32'h10, 24'd4);
    n_tot++; if (obs() !== exp_vec) $display("FAIL pre_rst_err got %h want %h", obs(), exp_vec); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_tot++; if (obs() !== 15'd0) $display("FAIL rst_async got %h want %h", obs(), 15'd0); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply_hdr(8'hFE, 8'h6C, 8'h20, 32'h10, 24'd4);
    n_tot++; if (obs() !== exp_vec) $display("FAIL rst_write_hdr got %h want %h", obs(), exp_vec); else n_pass++;
    idle_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    n_tot++; if (obs() !== 15'd0) $display("FAIL rst_wait_data got %h want %h", obs(), 15'd0); else n_pass++;
    rst_n = 1'b1;
    model_reset();
    apply_done(0, 0, 0, 0);
    n_tot++; if (writeDataIndication !== 1'b0 || obs() !== exp_vec) $display("FAIL done_after_rst got %h want %h", obs(), exp_vec); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0]  tla, instr, key;
    logic [31:0] addr;
    logic [23:0] len;
    logicalAddress = 8'($urandom);
    configKey      = 8'($urandom);
    for (int i = 0; i < 150; i++) begin
      tla = ($urandom_range(0, 6) == 0) ? 8'($urandom) : logicalAddress;
      key = ($urandom_range(0, 6) == 0) ? 8'($urandom) : configKey;
      case ($urandom_range(0, 3))
        0: instr = 8'($urandom);
        1: instr = {2'b01, 4'($urandom), 2'($urandom)};
        2: instr = {2'b01, 4'b0111, 2'($urandom)};
        default: instr = {2'b01, 1'b1, 3'($urandom), 2'($urandom)};
      endcase
      case ($urandom_range(0, 3))
        0: addr = 32'($urandom_range(0, 255));
        1: addr = 32'hFFFF - 32'($urandom_range(0, 9));
        2: addr = $urandom;
        default: addr = 32'($urandom_range(0, 65535));
      endcase
      case ($urandom_range(0, 2))
        0: len = 24'($urandom_range(0, 9));
        1: len = 24'($urandom_range(250, 260));
        default: len = 24'($urandom_range(0, 70000));
      endcase
      apply_hdr(tla, instr, key, addr, len);
      n_tot++; if (obs() !== exp_vec) $display("FAIL rand_hdr[%0d] got %h want %h", i, obs(), exp_vec); else n_pass++;
      if (m_pend == 3) begin
        if ($urandom_range(0, 2) == 0) begin
          apply_done(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          n_tot++; if (obs() !== exp_vec) $display("FAIL rand_stray[%0d] got %h want %h", i, obs(), exp_vec); else n_pass++;
        end
        apply_reply();
        n_tot++; if (obs() !== exp_vec) $display("FAIL rand_reply[%0d] got %h want %h", i, obs(), exp_vec); else n_pass++;
      end else if (m_pend != 0) begin
        if ($urandom_range(0, 2) == 0) begin
          apply_hdr(8'($urandom), 8'($urandom), 8'($urandom), $urandom, 24'($urandom));
          n_tot++; if (obs() !== exp_vec) $display("FAIL rand_busy[%0d] got %h want %h", i, obs(), exp_vec); else n_pass++;
        end
        apply_done($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        n_tot++; if (obs() !== exp_vec) $display("FAIL rand_done[%0d] got %h want %h", i, obs(), exp_vec); else n_pass++;
      end
    end
  endtask

  initial begin
    n_tot = 0; n_pass = 0;
    rst_n = 1'b0;
    configKey = 8'h20; logicalAddress = 8'hFE;
    hdrValid = 1'b0; hdrTla = 8'h0; hdrInstr = 8'h0; hdrKey = 8'h0; hdrAddr = 32'h0; hdrLen = 24'h0;
    dataDone = 1'b0; dataCrcErr = 1'b0; earlyEop = 1'b0; eep = 1'b0; tooMuchData = 1'b0;
    replyDone = 1'b0;
    model_reset();
    exp_vec = '0;
    test_reset();
    test_write_ok();
    test_key_bad();
    test_priority();
    test_limits();
    test_rmw();
    test_data_errors();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
